// File: rtl/regfile_ctx_seq.sv
// rtl/regfile_ctx_seq.sv - register file context save/restore sequencer
// Optional CTX_SP_UPDATE_EN: write the final frame address to r13 before DONE.
module regfile_ctx_seq #(
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_save_start,
    input  logic              i_restore_start,
    input  logic [15:0]       i_mask,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_rf_we,
    output logic [3:0]        o_rf_wr_ad,
    output logic [15:0]       o_rf_d,
    input  logic [15:0]       i_rf_wr_o,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_MEM,
        S_RFWR,
        S_DONE
`ifdef CTX_SP_UPDATE_EN
        , S_SPWB
`endif
    } state_t;

`ifdef CTX_SP_UPDATE_EN
    localparam state_t S_LAST = S_SPWB;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    state_t            state;
    state_t            state_nx;
    logic [3:0]        idx_q;
    logic [15:0]       mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic              save_q;
    logic [15:0]       data_q;
    logic              start;
    logic              last_idx;
    logic              sel;

    assign start    = i_save_start | i_restore_start;
    assign last_idx = (idx_q == 4'd15);
    assign sel      = mask_q[idx_q];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_SCAN;
            S_SCAN: begin
                if (sel)           state_nx = S_MEM;
                else if (last_idx) state_nx = S_LAST;
            end
            S_MEM: begin
                if (i_mem_ack) begin
                    if (!save_q)       state_nx = S_RFWR;
                    else if (last_idx) state_nx = S_LAST;
                    else               state_nx = S_SCAN;
                end
            end
            S_RFWR: state_nx = last_idx ? S_LAST : S_SCAN;
`ifdef CTX_SP_UPDATE_EN
            S_SPWB: state_nx = S_DONE;
`endif
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // data_q holds the word in flight: store data on save, load data on restore
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx_q  <= 4'd1;
            mask_q <= '0;
            addr_q <= '0;
            save_q <= 1'b0;
            data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= i_mask;
                        addr_q <= i_base_addr;
                        save_q <= i_save_start;
                        idx_q  <= 4'd1;
                    end
                end
                S_SCAN: begin
                    if (sel) begin
                        if (save_q) data_q <= i_rf_wr_o;
                    end else if (!last_idx) begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_MEM: begin
                    if (i_mem_ack) begin
                        addr_q <= addr_q + ADDR_W'(ADDR_STEP);
                        if (!save_q)        data_q <= i_mem_rdata;
                        else if (!last_idx) idx_q  <= idx_q + 4'd1;
                    end
                end
                S_RFWR: begin
                    if (!last_idx) idx_q <= idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_end_addr = addr_q;

    always_comb begin
        o_busy      = (state != S_IDLE);
        o_done      = 1'b0;
        o_rf_we     = 1'b0;
        o_rf_wr_ad  = 4'd0;
        o_rf_d      = 16'd0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 16'd0;
        case (state)
            S_SCAN: o_rf_wr_ad = idx_q;
            S_MEM: begin
                o_rf_wr_ad  = idx_q;
                o_mem_req   = 1'b1;
                o_mem_we    = save_q;
                o_mem_addr  = addr_q;
                o_mem_wdata = save_q ? data_q : 16'd0;
            end
            S_RFWR: begin
                o_rf_we    = 1'b1;
                o_rf_wr_ad = idx_q;
                o_rf_d     = data_q;
            end
`ifdef CTX_SP_UPDATE_EN
            S_SPWB: begin
                o_rf_we    = 1'b1;
                o_rf_wr_ad = 4'd13;
                o_rf_d     = 16'(addr_q);
            end
`endif
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// tb/tb_regfile_ctx_seq.sv - directed vector bench for regfile_ctx_seq
module tb_regfile_ctx_seq;

`ifdef CTX_SP_UPDATE_EN
    localparam int SPW = 1;
    localparam logic [15:0] R13_EXP = 16'h2008;
`else
    localparam int SPW = 0;
    localparam logic [15:0] R13_EXP = 16'hD00D;
`endif

    typedef struct {
        bit          ss;
        bit          rs;
        logic [15:0] mask;
        logic [15:0] base;
        int          lat;
        logic [15:0] clr;
        logic [15:0] exp_end;
        int          exp_lat;
        int          exp_xfer;
        int          exp_rfwe;
        bit          ck0_rf;
        logic [15:0] ck0_ad;
        logic [15:0] ck0_v;
        bit          ck1_rf;
        logic [15:0] ck1_ad;
        logic [15:0] ck1_v;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, save_start, restore_start;
    logic [15:0] mask, base;
    logic        busy, done, rf_we, mem_req, mem_we, mem_ack;
    logic [15:0] end_addr, rf_d, rf_rd, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rf_wr_ad;

    logic [15:0] rf [0:15];
    logic [15:0] mem [0:65535];

    int          total = 0, bad = 0;
    int          ncyc = 0, n_xfer = 0, n_rfwe = 0, n_done = 0;
    int          done_cyc = 0, last_we_cyc = 0, mem_lat = 0, wait_cnt = 0;
    logic [3:0]  last_we_ad;
    logic [15:0] last_we_d, end_seen, hold_addr, hold_wdata;
    logic        hold_we, holding, in_save;

    always #5 clk = ~clk;

    assign rf_rd     = rf[rf_wr_ad];
    assign mem_rdata = mem[mem_addr];

    regfile_ctx_seq #(.ADDR_W(16), .ADDR_STEP(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_save_start(save_start), .i_restore_start(restore_start),
        .i_mask(mask), .i_base_addr(base),
        .o_busy(busy), .o_done(done), .o_end_addr(end_addr),
        .o_rf_we(rf_we), .o_rf_wr_ad(rf_wr_ad), .o_rf_d(rf_d), .i_rf_wr_o(rf_rd),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, update memory/regfile models, drive inputs.
    task automatic step(input logic ss, input logic rs);
        @(negedge clk);
        ncyc++;
        if (mem_req) begin
            if (holding)
                chk("mem_hold", {mem_addr, mem_we, mem_wdata}, {hold_addr, hold_we, hold_wdata});
            if (wait_cnt >= mem_lat) begin
                mem_ack = 1'b1;
                n_xfer++;
                if (mem_we) mem[mem_addr] = mem_wdata;
                wait_cnt = 0;
                holding  = 1'b0;
            end else begin
                mem_ack    = 1'b0;
                wait_cnt++;
                holding    = 1'b1;
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            holding  = 1'b0;
        end
        if (rf_we) begin
            n_rfwe++;
            chk("rf_we_r0", {63'd0, rf_wr_ad == 4'd0}, 64'd0);
            chk("rf_we_in_save", {63'd0, in_save && !(SPW != 0 && rf_wr_ad == 4'd13)}, 64'd0);
            rf[rf_wr_ad] = rf_d;
            last_we_cyc  = ncyc;
            last_we_ad   = rf_wr_ad;
            last_we_d    = rf_d;
        end
        if (done) begin
            n_done++;
            done_cyc = ncyc;
            end_seen = end_addr;
        end
        save_start    = ss;
        restore_start = rs;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int x0, w0, d0, k, lat;
        mem_lat = v.lat;
        for (int i = 0; i < 16; i++) if (v.clr[i]) rf[i] = 16'h0000;
        mask    = v.mask;
        base    = v.base;
        in_save = v.ss;
        x0 = n_xfer; w0 = n_rfwe; d0 = n_done;
        step(v.ss, v.rs);
        k = ncyc;
        for (int t = 0; t < 300 && n_done == d0; t++) step(1'b0, 1'b0);
        lat = (n_done == d0) ? -1 : done_cyc - k;
        chk({tag, "_latency"}, lat, v.exp_lat);
`ifdef CTX_SP_UPDATE_EN
        chk({tag, "_spwb"}, {last_we_ad, last_we_d, 32'(last_we_cyc)}, {4'd13, v.exp_end, 32'(done_cyc - 1)});
`endif
        repeat (4) step(1'b0, 1'b0);
        chk({tag, "_done_count"}, n_done - d0, 1);
        chk({tag, "_end_addr"}, end_seen, v.exp_end);
        chk({tag, "_xfers"}, n_xfer - x0, v.exp_xfer);
        chk({tag, "_rf_writes"}, n_rfwe - w0, v.exp_rfwe);
        chk({tag, "_data0"}, v.ck0_rf ? rf[v.ck0_ad[3:0]] : mem[v.ck0_ad], v.ck0_v);
        chk({tag, "_data1"}, v.ck1_rf ? rf[v.ck1_ad[3:0]] : mem[v.ck1_ad], v.ck1_v);
    endtask

    vec_t vt [6];
    vec_t vr;

    initial begin
        int d0, x0, k;
        vt[0] = '{1, 0, 16'h0006, 16'h1000, 0, 16'h0000, 16'h1004, 18 + SPW, 2, SPW,
                  0, 16'h1000, 16'hAAAA, 0, 16'h1002, 16'h5555};
        vt[1] = '{0, 1, 16'h0006, 16'h1000, 3, 16'h0006, 16'h1004, 26 + SPW, 2, 2 + SPW,
                  1, 16'd1, 16'hAAAA, 1, 16'd2, 16'h5555};
        vt[2] = '{1, 0, 16'h0000, 16'h4000, 0, 16'h0000, 16'h4000, 16 + SPW, 0, SPW,
                  1, 16'd0, 16'h0BAD, 0, 16'h4000, 16'h0000};
        vt[3] = '{0, 1, 16'h0001, 16'h4000, 0, 16'h0000, 16'h4000, 16 + SPW, 0, SPW,
                  1, 16'd0, 16'h0BAD, 1, 16'd1, 16'hAAAA};
        vt[4] = '{1, 1, 16'h8000, 16'hFFFE, 1, 16'h0000, 16'h0000, 18 + SPW, 1, SPW,
                  0, 16'hFFFE, 16'h1234, 1, 16'd15, 16'h1234};
        vt[5] = '{1, 0, 16'h00F0, 16'h2000, 0, 16'h0000, 16'h2008, 20 + SPW, 4, SPW,
                  1, 16'd13, R13_EXP, 0, 16'h2006, 16'h7777};

        rst_n = 1'b0; save_start = 1'b0; restore_start = 1'b0;
        mask = 16'h0; base = 16'h0; mem_ack = 1'b0; in_save = 1'b0; holding = 1'b0;
        hold_addr = '0; hold_we = 1'b0; hold_wdata = '0;
        last_we_ad = '0; last_we_d = '0; end_seen = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h1111);
        rf[0] = 16'h0BAD; rf[1] = 16'hAAAA; rf[2] = 16'h5555; rf[13] = 16'hD00D; rf[15] = 16'h1234;

        repeat (3) step(1'b0, 1'b0);
        chk("reset_ctl", {busy, done, rf_we, mem_req, mem_we, rf_wr_ad}, 64'd0);
        chk("reset_data", {end_addr, rf_d, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // start pulse while busy is ignored
        in_save = 1'b1; mask = 16'h8000; base = 16'hFFFE; mem_lat = 0;
        d0 = n_done; x0 = n_xfer;
        step(1'b1, 1'b0);
        k = ncyc;
        step(1'b0, 1'b0);
        mask = 16'h0002; base = 16'h5000;
        step(1'b0, 1'b1);
        for (int t = 0; t < 300 && n_done == d0; t++) step(1'b0, 1'b0);
        chk("busy_ign_latency", (n_done == d0) ? -1 : done_cyc - k, 17 + SPW);
        repeat (25) step(1'b0, 1'b0);
        chk("busy_ign_done_count", n_done - d0, 1);
        chk("busy_ign_xfers", n_xfer - x0, 1);
        chk("busy_ign_end", end_seen, 16'h0000);
        chk("busy_ign_r1", rf[1], 16'hAAAA);

        // reset while a store is waiting for ack
        mask = 16'h001E; base = 16'h3000; mem_lat = 4;
        d0 = n_done;
        step(1'b1, 1'b0);
        for (int t = 0; t < 40 && !mem_req; t++) step(1'b0, 1'b0);
        chk("mid_req_seen", mem_req, 1'b1);
        step(1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        chk("mid_reset_outputs", {mem_req, busy, done}, 3'b000);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("mid_reset_no_done", n_done - d0, 0);
        chk("mid_reset_no_store", mem[16'h3000], 16'h0000);

        vr = '{1, 0, 16'h001E, 16'h3000, 0, 16'h0000, 16'h3008, 20 + SPW, 4, SPW,
               0, 16'h3000, 16'hAAAA, 0, 16'h3006, 16'h4444};
        run_vec(vr, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
